// File: rtl/eros_obi_rr_arbiter.sv
// Round-robin arbiter sharing the EROS external OBI manager port between NREQ requesters.
// Optional response watchdog is enabled with `define EROS_OBI_ARB_TIMEOUT_EN.
module eros_obi_rr_arbiter #(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUT    = 2,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NREQ-1:0]              slv_req_i,
  output logic [NREQ-1:0]              slv_gnt_o,
  input  logic [NREQ*ADDR_WIDTH-1:0]   slv_addr_i,
  input  logic [NREQ-1:0]              slv_we_i,
  input  logic [NREQ*DATA_WIDTH/8-1:0] slv_be_i,
  input  logic [NREQ*DATA_WIDTH-1:0]   slv_wdata_i,
  output logic [NREQ-1:0]              slv_rvalid_o,
  output logic [DATA_WIDTH-1:0]        slv_rdata_o,
  output logic                         mst_req_o,
  input  logic                         mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]        mst_addr_o,
  output logic                         mst_we_o,
  output logic [DATA_WIDTH/8-1:0]      mst_be_o,
  output logic [DATA_WIDTH-1:0]        mst_wdata_o,
  input  logic                         mst_rvalid_i,
  input  logic [DATA_WIDTH-1:0]        mst_rdata_i,
  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         timeout_o,
  input  logic                         timeout_clr_i
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int SEL_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state;
  logic [SEL_W-1:0] rr_ptr, hold_sel, arb_sel, sel, offset, head;
  logic [SEL_W:0]   sum;
  logic [NREQ-1:0]  req_rot;
  logic             arb_valid, space, push, pop;
  logic [SEL_W-1:0] fifo_mem [MAX_OUT];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // Rotate the request vector so bit 0 is the pointer position; the lowest set bit wins.
  always_comb begin
    req_rot   = NREQ'({slv_req_i, slv_req_i} >> rr_ptr);
    arb_valid = |slv_req_i;
    offset    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_rot[k]) offset = SEL_W'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= (SEL_W+1)'(NREQ)) sum = sum - (SEL_W+1)'(NREQ);
    arb_sel = sum[SEL_W-1:0];
  end

  // A full FIFO may still accept a new transfer in the cycle its head is popped.
  assign pop           = mst_rvalid_i && (count != '0);
  assign space         = (count != CNT_W'(MAX_OUT)) || pop;
  assign mst_req_o     = (state == HOLD) || (arb_valid && space);
  assign sel           = (state == HOLD) ? hold_sel : arb_sel;
  assign push          = mst_req_o && mst_gnt_i;
  assign head          = fifo_mem[rd_ptr];
  assign outstanding_o = count;
  assign slv_rdata_o   = pop ? mst_rdata_i : '0;

  always_comb begin
    mst_addr_o   = '0;
    mst_we_o     = 1'b0;
    mst_be_o     = '0;
    mst_wdata_o  = '0;
    slv_gnt_o    = '0;
    slv_rvalid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (mst_req_o && (sel == SEL_W'(i))) begin
        mst_addr_o   = slv_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        mst_we_o     = slv_we_i[i];
        mst_be_o     = slv_be_i[i*BE_W +: BE_W];
        mst_wdata_o  = slv_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
        slv_gnt_o[i] = mst_gnt_i;
      end
      if (pop && (head == SEL_W'(i))) slv_rvalid_o[i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      hold_sel <= '0;
      rr_ptr   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mst_req_o && !mst_gnt_i) begin
            state    <= HOLD;
            hold_sel <= arb_sel;
          end
        end
        HOLD: begin
          if (mst_gnt_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push) begin
        rr_ptr <= (sel == SEL_W'(NREQ - 1)) ? '0 : sel + SEL_W'(1);
        wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= sel;
  end

`ifdef EROS_OBI_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Counts response-less cycles while anything is outstanding; saturates at TIMEOUT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (timeout_clr_i) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (mst_rvalid_i || (count == '0)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(TIMEOUT)) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_cnt == WD_W'(TIMEOUT - 1)) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = timeout_clr_i & (TIMEOUT > 0);
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_eros_obi_rr_arbiter.sv
// Randomized and directed bench for eros_obi_rr_arbiter against a queue-based reference model.
module tb_eros_obi_rr_arbiter;

  localparam int NREQ    = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int BW      = DW / 8;
  localparam int MAX_OUT = 2;
  localparam int TIMEOUT = 16;
  localparam int CW      = $clog2(MAX_OUT + 1);

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NREQ-1:0]   slv_req_i, slv_gnt_o, slv_we_i, slv_rvalid_o;
  logic [NREQ*AW-1:0] slv_addr_i;
  logic [NREQ*BW-1:0] slv_be_i;
  logic [NREQ*DW-1:0] slv_wdata_i;
  logic [DW-1:0]     slv_rdata_o;
  logic              mst_req_o, mst_gnt_i, mst_we_o, mst_rvalid_i;
  logic [AW-1:0]     mst_addr_o;
  logic [BW-1:0]     mst_be_o;
  logic [DW-1:0]     mst_wdata_o, mst_rdata_i;
  logic [CW-1:0]     outstanding_o;
  logic              timeout_o, timeout_clr_i;

  always #5 clk_i = ~clk_i;

  eros_obi_rr_arbiter #(
    .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slv_req_i(slv_req_i), .slv_gnt_o(slv_gnt_o), .slv_addr_i(slv_addr_i),
    .slv_we_i(slv_we_i), .slv_be_i(slv_be_i), .slv_wdata_i(slv_wdata_i),
    .slv_rvalid_o(slv_rvalid_o), .slv_rdata_o(slv_rdata_o),
    .mst_req_o(mst_req_o), .mst_gnt_i(mst_gnt_i), .mst_addr_o(mst_addr_o),
    .mst_we_o(mst_we_o), .mst_be_o(mst_be_o), .mst_wdata_o(mst_wdata_o),
    .mst_rvalid_i(mst_rvalid_i), .mst_rdata_i(mst_rdata_i),
    .outstanding_o(outstanding_o), .timeout_o(timeout_o), .timeout_clr_i(timeout_clr_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: round-robin pointer, ID queue, held request and watchdog.
  int m_ptr;
  int m_q[$];
  bit m_lock;
  int m_lock_idx;
  int m_wd;
  bit m_to;

  logic [NREQ-1:0] obs_gnt, obs_rvalid;
  logic [AW-1:0]   obs_addr;
  logic [DW-1:0]   obs_rdata;
  logic            obs_req, obs_to;
  logic [CW-1:0]   obs_out;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_ptr = 0;
    m_q.delete();
    m_lock = 1'b0;
    m_lock_idx = 0;
    m_wd = 0;
    m_to = 1'b0;
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    slv_req_i = '0; slv_addr_i = '0; slv_we_i = '0; slv_be_i = '0; slv_wdata_i = '0;
    mst_gnt_i = 1'b0; mst_rvalid_i = 1'b0; mst_rdata_i = '0; timeout_clr_i = 1'b0;
    @(negedge clk_i);
    checkOutput("reset_mst_req", mst_req_o, 0);
    checkOutput("reset_mst_addr", mst_addr_o, 0);
    checkOutput("reset_slv_gnt", slv_gnt_o, 0);
    checkOutput("reset_slv_rvalid", slv_rvalid_o, 0);
    checkOutput("reset_slv_rdata", slv_rdata_o, 0);
    checkOutput("reset_outstanding", outstanding_o, 0);
    checkOutput("reset_timeout", timeout_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    modelReset();
  endtask

  // Drives one cycle, compares every output to the model, then advances the model at the edge.
  task automatic applyStimulus(input logic [NREQ-1:0] req, input bit gnt, input bit rv,
                               input logic [DW-1:0] rd, input bit clr);
    bit e_req, pop, acc;
    int e_sel, sz;
    logic [NREQ-1:0] e_gnt, e_rv;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wdata;
    logic e_we;
    slv_req_i = req; mst_gnt_i = gnt; mst_rvalid_i = rv; mst_rdata_i = rd; timeout_clr_i = clr;
    @(negedge clk_i);
    sz = m_q.size();
    pop = rv && (sz > 0);
    e_req = 1'b0;
    e_sel = 0;
    if (m_lock) begin
      e_req = 1'b1;
      e_sel = m_lock_idx;
    end else if ((req != '0) && ((sz < MAX_OUT) || pop)) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (req[(m_ptr + k) % NREQ]) e_sel = (m_ptr + k) % NREQ;
      e_req = 1'b1;
    end
    acc = e_req && gnt;
    e_gnt = '0;
    if (acc) e_gnt[e_sel] = 1'b1;
    e_rv = '0;
    if (pop) e_rv[m_q[0]] = 1'b1;
    e_addr = e_req ? slv_addr_i[e_sel*AW +: AW] : '0;
    e_be = e_req ? slv_be_i[e_sel*BW +: BW] : '0;
    e_wdata = e_req ? slv_wdata_i[e_sel*DW +: DW] : '0;
    e_we = e_req ? slv_we_i[e_sel] : 1'b0;
    checkOutput("mst_req", mst_req_o, e_req);
    checkOutput("mst_addr", mst_addr_o, e_addr);
    checkOutput("mst_we", mst_we_o, e_we);
    checkOutput("mst_be", mst_be_o, e_be);
    checkOutput("mst_wdata", mst_wdata_o, e_wdata);
    checkOutput("slv_gnt", slv_gnt_o, e_gnt);
    checkOutput("slv_rvalid", slv_rvalid_o, e_rv);
    checkOutput("slv_rdata", slv_rdata_o, pop ? rd : '0);
    checkOutput("outstanding", outstanding_o, sz);
    checkOutput("timeout", timeout_o, m_to);
    obs_gnt = slv_gnt_o; obs_rvalid = slv_rvalid_o; obs_addr = mst_addr_o;
    obs_rdata = slv_rdata_o; obs_req = mst_req_o; obs_out = outstanding_o; obs_to = timeout_o;
    @(posedge clk_i);
`ifdef EROS_OBI_ARB_TIMEOUT_EN
    if (clr) begin
      m_wd = 0;
      m_to = 1'b0;
    end else if (rv || (sz == 0)) begin
      m_wd = 0;
    end else if (m_wd < TIMEOUT) begin
      m_wd++;
      if (m_wd == TIMEOUT) m_to = 1'b1;
    end
`endif
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      m_q.push_back(e_sel);
      m_ptr = (e_sel + 1) % NREQ;
      m_lock = 1'b0;
    end else if (e_req) begin
      m_lock = 1'b1;
      m_lock_idx = e_sel;
    end
    #1;
  endtask

  initial begin
    doReset();

    // Single requester read
    slv_addr_i[0 +: AW] = 32'h0000_1000;
    applyStimulus(3'b001, 1, 0, '0, 0);
    checkOutput("single_gnt", obs_gnt, 3'b001);
    checkOutput("single_addr", obs_addr, 32'h0000_1000);
    applyStimulus(3'b000, 0, 0, '0, 0);
    checkOutput("single_out_1", obs_out, 1);
    applyStimulus(3'b000, 0, 0, '0, 0);
    applyStimulus(3'b000, 0, 1, 32'hCAFE_F00D, 0);
    checkOutput("single_rvalid", obs_rvalid, 3'b001);
    checkOutput("single_rdata", obs_rdata, 32'hCAFE_F00D);
    applyStimulus(3'b000, 0, 0, '0, 0);
    checkOutput("single_out_0", obs_out, 0);

    // Contention: grants alternate 0,1,0,1
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b011, 1, 1, 32'h1234_0000 + i, 0);
      checkOutput("contention_gnt", obs_gnt, (i % 2 == 0) ? 3'b001 : 3'b010);
    end

    // Backpressure: held selection ignores the later req0
    doReset();
    slv_addr_i[0 +: AW]  = 32'h1111_0000;
    slv_addr_i[AW +: AW] = 32'h2222_0000;
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i == 0) ? 3'b010 : 3'b011, 0, 0, '0, 0);
      checkOutput("bp_addr", obs_addr, 32'h2222_0000);
    end
    applyStimulus(3'b011, 1, 0, '0, 0);
    checkOutput("bp_gnt_req1", obs_gnt, 3'b010);
    applyStimulus(3'b001, 1, 0, '0, 0);
    checkOutput("bp_gnt_req0", obs_gnt, 3'b001);
    checkOutput("bp_addr_req0", obs_addr, 32'h1111_0000);

    // Outstanding limit, push+pop while full, in-order return, stray rvalid
    doReset();
    applyStimulus(3'b011, 1, 0, '0, 0);
    applyStimulus(3'b011, 1, 0, '0, 0);
    applyStimulus(3'b011, 1, 0, '0, 0);
    checkOutput("limit_req_blocked", obs_req, 0);
    checkOutput("limit_out_full", obs_out, 2);
    applyStimulus(3'b011, 1, 0, '0, 0);
    applyStimulus(3'b011, 1, 1, 32'hA1, 0);
    checkOutput("limit_resp0", obs_rvalid, 3'b001);
    checkOutput("limit_push_pop_gnt", obs_gnt, 3'b001);
    applyStimulus(3'b000, 0, 1, 32'hA2, 0);
    checkOutput("limit_out_stay", obs_out, 2);
    checkOutput("limit_resp1", obs_rvalid, 3'b010);
    applyStimulus(3'b000, 0, 1, 32'hA3, 0);
    checkOutput("limit_resp2", obs_rvalid, 3'b001);
    applyStimulus(3'b000, 0, 1, 32'hA4, 0);
    checkOutput("stray_rvalid", obs_rvalid, 3'b000);
    checkOutput("stray_rdata", obs_rdata, 0);

    // Watchdog
    doReset();
    applyStimulus(3'b001, 1, 0, '0, 0);
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(3'b000, 0, 0, '0, 0);
`ifdef EROS_OBI_ARB_TIMEOUT_EN
      if (i == 16) checkOutput("wd_not_yet", obs_to, 0);
      if (i == 17) checkOutput("wd_set", obs_to, 1);
`else
      if (i == 17) checkOutput("wd_tied_off", obs_to, 0);
`endif
    end
    applyStimulus(3'b000, 0, 0, '0, 1);
    applyStimulus(3'b000, 0, 0, '0, 0);
    checkOutput("wd_cleared", obs_to, 0);
    applyStimulus(3'b000, 0, 1, 32'h55, 0);

    // Randomized traffic against the model
    doReset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      slv_addr_i  = {$urandom, $urandom, $urandom};
      slv_wdata_i = {$urandom, $urandom, $urandom};
      slv_be_i    = NREQ*BW'($urandom);
      slv_we_i    = NREQ'($urandom);
      applyStimulus(NREQ'($urandom), 1'($urandom), $urandom_range(0, 99) < 40,
                    $urandom, $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
